load_align_unit: RTL and testbench



---
 rtl/load_align_pkg.sv | 31 +++
 rtl/load_align_unit_extract.sv | 32 +++
 rtl/load_align_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_align_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_align_pkg.sv
// Shared types and helpers for the load alignment unit.
package load_align_pkg;

  localparam logic [2:0] LOAD_B  = 3'd0;
  localparam logic [2:0] LOAD_H  = 3'd1;
  localparam logic [2:0] LOAD_W  = 3'd2;
  localparam logic [2:0] LOAD_D  = 3'd3;
  localparam logic [2:0] LOAD_BU = 3'd4;
  localparam logic [2:0] LOAD_HU = 3'd5;
  localparam logic [2:0] LOAD_WU = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Access size in bytes; the signed/unsigned variants share the low two funct3 bits.
  function automatic logic [3:0] size_of(input logic [2:0] ltype);
    case (ltype[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Byte selection from the {hi,lo} bus-word pair plus sign/zero extension.
module load_extract
  import load_align_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  lo,
  input  logic [XLEN-1:0]  hi,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       ltype,
  output logic [XLEN-1:0]  data_c
);

  logic [XLEN-1:0] shifted;

  // Signed width casts sign-extend; unsigned ones zero-fill.
  always_comb begin
    shifted = XLEN'({hi, lo} >> {off, 3'b000});
    data_c  = shifted;
    case (ltype)
      LOAD_B:  data_c = XLEN'($signed(shifted[7:0]));
      LOAD_H:  data_c = XLEN'($signed(shifted[15:0]));
      LOAD_W:  data_c = XLEN'($signed(shifted[31:0]));
      LOAD_BU: data_c = XLEN'(shifted[7:0]);
      LOAD_HU: data_c = XLEN'(shifted[15:0]);
      LOAD_WU: data_c = XLEN'(shifted[31:0]);
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load aligner: one request in flight, one or two aligned bus reads.
// Build option LOAD_ALIGN_SPLIT_EN serves word-crossing loads with two beats.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_misaligned,
  output logic              out_illegal
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  state_t             state, state_next;
  logic [2:0]         type_q, type_next;
  logic [OFF_W-1:0]   off_q, off_next;
  logic [XLEN-1:0]    lo_q, lo_next;
`ifdef LOAD_ALIGN_SPLIT_EN
  logic               cross_q, cross_next;
`endif

  logic               in_ready_next, mem_req_valid_next, out_valid_next;
  logic               out_mis_next, out_ill_next;
  logic [ADDR_W-1:0]  mem_addr_next;
  logic [XLEN-1:0]    out_data_next;
  logic [XLEN-1:0]    ext_lo, ext_hi, ext_data_c;

  logic [OFF_W-1:0]   in_off;
  logic [4:0]         in_end;
  logic               in_cross, in_illegal;
  logic [ADDR_W-1:0]  in_word;

  // Request classification at acceptance time.
  always_comb begin
    in_off     = in_addr[OFF_W-1:0];
    in_end     = 5'(in_off) + 5'(size_of(in_type));
    in_cross   = in_end > 5'(BYTES);
    in_illegal = (in_type == 3'b111) ||
                 ((XLEN == 32) && ((in_type == LOAD_D) || (in_type == LOAD_WU)));
    in_word    = in_addr & ~ADDR_W'(BYTES - 1);
  end

  load_extract #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_extract (
    .lo     (ext_lo),
    .hi     (ext_hi),
    .off    (off_q),
    .ltype  (type_q),
    .data_c (ext_data_c)
  );

  // Next-state and next-output logic; extraction sees the beat arriving this cycle.
  always_comb begin
    state_next    = state;
    type_next     = type_q;
    off_next      = off_q;
    lo_next       = lo_q;
    mem_addr_next = mem_addr;
    out_data_next = out_data;
    out_mis_next  = out_misaligned;
    out_ill_next  = out_illegal;
    ext_lo        = lo_q;
    ext_hi        = '0;
`ifdef LOAD_ALIGN_SPLIT_EN
    cross_next    = cross_q;
`endif

    case (state)
      IDLE: begin
        if (in_valid) begin
          type_next = in_type;
          off_next  = in_off;
          if (in_illegal) begin
            state_next    = DONE;
            out_ill_next  = 1'b1;
            out_data_next = '0;
          end else begin
`ifdef LOAD_ALIGN_SPLIT_EN
            cross_next    = in_cross;
            state_next    = REQ0;
            mem_addr_next = in_word;
`else
            if (in_cross) begin
              state_next    = DONE;
              out_mis_next  = 1'b1;
              out_data_next = '0;
            end else begin
              state_next    = REQ0;
              mem_addr_next = in_word;
            end
`endif
          end
        end
      end

      REQ0: begin
        if (mem_req_ready) state_next = WAIT0;
      end

      WAIT0: begin
        ext_lo = mem_rdata;
        if (mem_rsp_valid) begin
          lo_next = mem_rdata;
`ifdef LOAD_ALIGN_SPLIT_EN
          if (cross_q) begin
            state_next    = REQ1;
            mem_addr_next = mem_addr + ADDR_W'(BYTES);
          end else begin
            state_next    = DONE;
            out_data_next = ext_data_c;
          end
`else
          state_next    = DONE;
          out_data_next = ext_data_c;
`endif
        end
      end

`ifdef LOAD_ALIGN_SPLIT_EN
      REQ1: begin
        if (mem_req_ready) state_next = WAIT1;
      end

      WAIT1: begin
        ext_hi = mem_rdata;
        if (mem_rsp_valid) begin
          state_next    = DONE;
          out_data_next = ext_data_c;
        end
      end
`endif

      DONE: begin
        if (out_ready) begin
          state_next    = IDLE;
          out_data_next = '0;
          out_mis_next  = 1'b0;
          out_ill_next  = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase

    in_ready_next      = (state_next == IDLE);
    mem_req_valid_next = (state_next == REQ0) || (state_next == REQ1);
    out_valid_next     = (state_next == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      type_q         <= '0;
      off_q          <= '0;
      lo_q           <= '0;
      in_ready       <= 1'b1;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_misaligned <= 1'b0;
      out_illegal    <= 1'b0;
    end else begin
      state          <= state_next;
      type_q         <= type_next;
      off_q          <= off_next;
      lo_q           <= lo_next;
      in_ready       <= in_ready_next;
      mem_req_valid  <= mem_req_valid_next;
      mem_addr       <= mem_addr_next;
      out_valid      <= out_valid_next;
      out_data       <= out_data_next;
      out_misaligned <= out_mis_next;
      out_illegal    <= out_ill_next;
    end
  end

`ifdef LOAD_ALIGN_SPLIT_EN
  always_ff @(posedge clk) begin
    if (reset) cross_q <= 1'b0;
    else       cross_q <= cross_next;
  end
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: RV32 instance plus an RV64 instance.
module tb_load_align_unit;
  import load_align_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;
  int          req_hs = 0;

  // RV32 instance
  logic        in_valid, in_ready, mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic        out_valid, out_ready, out_misaligned, out_illegal;
  logic [2:0]  in_type;
  logic [31:0] in_addr, mem_addr, mem_rdata, out_data;

  // RV64 instance
  logic        in_valid64, in_ready64, mem_req_valid64, mem_req_ready64, mem_rsp_valid64;
  logic        out_valid64, out_ready64, out_mis64, out_ill64;
  logic [2:0]  in_type64;
  logic [31:0] in_addr64, mem_addr64;
  logic [63:0] mem_rdata64, out_data64;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req_valid && mem_req_ready) req_hs++;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_addr(in_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misaligned(out_misaligned), .out_illegal(out_illegal)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_type(in_type64), .in_addr(in_addr64),
    .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64), .mem_addr(mem_addr64),
    .mem_rsp_valid(mem_rsp_valid64), .mem_rdata(mem_rdata64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_misaligned(out_mis64), .out_illegal(out_ill64)
  );

  task automatic send_req(input logic [2:0] t, input logic [31:0] a);
    @(negedge clk);
    in_valid = 1'b1; in_type = t; in_addr = a;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a bus request, accept it, then return one response beat.
  task automatic serve_beat(input logic [31:0] data, output logic ok, output logic [31:0] addr);
    ok = 1'b0; addr = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_req_valid === 1'b1) begin ok = 1'b1; addr = mem_addr; end
      else @(negedge clk);
    end
    if (ok) begin
      mem_req_ready = 1'b1; @(negedge clk); mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = data; @(negedge clk); mem_rsp_valid = 1'b0;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if ({out_misaligned, out_illegal} !== 2'b00) begin failures++; $display("FAIL reset_exc: got %b expected 00", {out_misaligned, out_illegal}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
  endtask

  task automatic test_inword();
    logic [2:0]  t  [7] = '{LOAD_B, LOAD_HU, LOAD_H, LOAD_BU, LOAD_W, LOAD_B, LOAD_H};
    logic [31:0] a  [7] = '{32'h103, 32'h101, 32'h102, 32'h000, 32'h200, 32'h001, 32'h001};
    logic [31:0] d  [7] = '{32'h80FF_0000, 32'h00AB_CD00, 32'h8001_0000, 32'h0000_00F0,
                            32'hDEAD_BEEF, 32'h0000_7F00, 32'h00FE_DC00};
    logic [31:0] ma [7] = '{32'h100, 32'h100, 32'h100, 32'h000, 32'h200, 32'h000, 32'h000};
    logic [31:0] e  [7] = '{32'hFFFF_FF80, 32'h0000_ABCD, 32'hFFFF_8001, 32'h0000_00F0,
                            32'hDEAD_BEEF, 32'h0000_007F, 32'hFFFF_FEDC};
    logic ok; logic [31:0] addr;
    for (int i = 0; i < 7; i++) begin
      send_req(t[i], a[i]);
      serve_beat(d[i], ok, addr);
      checks++; if (ok !== 1'b1 || addr !== ma[i]) begin failures++; $display("FAIL inword_req[%0d]: got ok=%b addr=%h expected ok=1 addr=%h", i, ok, addr, ma[i]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL inword_latency[%0d]: got out_valid=%b expected 1", i, out_valid); end
      checks++; if (out_data !== e[i]) begin failures++; $display("FAIL inword_data[%0d]: got %h expected %h", i, out_data, e[i]); end
      checks++; if ({out_misaligned, out_illegal} !== 2'b00) begin failures++; $display("FAIL inword_exc[%0d]: got %b expected 00", i, {out_misaligned, out_illegal}); end
      release_out();
    end
  endtask

  task automatic test_cross();
    logic [2:0]  t  [2] = '{LOAD_W, LOAD_H};
    logic [31:0] a  [2] = '{32'h102, 32'hFFFF_FFFF};
    logic [31:0] lo [2] = '{32'h4433_1111, 32'h3400_0000};
    logic [31:0] hi [2] = '{32'h2222_6655, 32'h0000_0012};
    logic [31:0] a0 [2] = '{32'h100, 32'hFFFF_FFFC};
    logic [31:0] a1 [2] = '{32'h104, 32'h0000_0000};
    logic [31:0] e  [2] = '{32'h6655_4433, 32'h0000_1234};
    logic ok; logic [31:0] addr;
    int hs0;
    for (int i = 0; i < 2; i++) begin
      hs0 = req_hs;
      send_req(t[i], a[i]);
`ifdef LOAD_ALIGN_SPLIT_EN
      serve_beat(lo[i], ok, addr);
      checks++; if (ok !== 1'b1 || addr !== a0[i]) begin failures++; $display("FAIL cross_req0[%0d]: got ok=%b addr=%h expected addr=%h", i, ok, addr, a0[i]); end
      serve_beat(hi[i], ok, addr);
      checks++; if (ok !== 1'b1 || addr !== a1[i]) begin failures++; $display("FAIL cross_req1[%0d]: got ok=%b addr=%h expected addr=%h", i, ok, addr, a1[i]); end
      checks++; if (out_valid !== 1'b1 || out_data !== e[i]) begin failures++; $display("FAIL cross_data[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, e[i]); end
      checks++; if (out_misaligned !== 1'b0) begin failures++; $display("FAIL cross_mis[%0d]: got %b expected 0", i, out_misaligned); end
`else
      ok = 1'b0; addr = lo[i] ^ hi[i] ^ a0[i] ^ a1[i] ^ e[i];
      checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1) begin failures++; $display("FAIL cross_mis[%0d]: got v=%b mis=%b expected v=1 mis=1", i, out_valid, out_misaligned); end
      checks++; if (mem_req_valid !== 1'b0 || req_hs != hs0) begin failures++; $display("FAIL cross_nobus[%0d]: got req=%b hs=%0d expected req=0 hs=%0d", i, mem_req_valid, req_hs, hs0); end
      checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL cross_ill[%0d]: got %b expected 0", i, out_illegal); end
`endif
      release_out();
    end
  endtask

  task automatic test_illegal();
    logic [2:0] t [3] = '{3'b111, LOAD_WU, LOAD_D};
    int hs0;
    for (int i = 0; i < 3; i++) begin
      hs0 = req_hs;
      send_req(t[i], 32'h40);
      checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin failures++; $display("FAIL illegal[%0d]: got v=%b ill=%b expected v=1 ill=1", i, out_valid, out_illegal); end
      checks++; if (mem_req_valid !== 1'b0 || req_hs != hs0 || out_misaligned !== 1'b0) begin failures++; $display("FAIL illegal_nobus[%0d]: got req=%b mis=%b expected 0 0", i, mem_req_valid, out_misaligned); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic ok; logic [31:0] addr;
    send_req(LOAD_W, 32'h208);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h208 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_req_hold[%0d]: got req=%b addr=%h rdy=%b expected 1 208 0", i, mem_req_valid, mem_addr, in_ready); end
      if (i == 1) begin mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    serve_beat(32'h1234_5678, ok, addr);
    checks++; if (ok !== 1'b1 || addr !== 32'h208) begin failures++; $display("FAIL bp_req: got ok=%b addr=%h expected 1 208", ok, addr); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_out_hold[%0d]: got v=%b %h rdy=%b expected 1 12345678 0", i, out_valid, out_data, in_ready); end
      if (i == 0) begin mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic ok; logic [31:0] addr;
    send_req(LOAD_W, 32'h300);
    mem_req_ready = 1'b1; @(negedge clk); mem_req_ready = 1'b0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_state: got rdy=%b v=%b req=%b expected 1 0 0", in_ready, out_valid, mem_req_valid); end
    checks++; if (mem_addr !== 32'h0 || out_data !== 32'h0) begin failures++; $display("FAIL rstmid_zero: got addr=%h data=%h expected 0 0", mem_addr, out_data); end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; @(negedge clk); mem_rsp_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_late_rsp: got rdy=%b v=%b expected 1 0", in_ready, out_valid); end
    send_req(LOAD_B, 32'h301);
    serve_beat(32'h0000_7F00, ok, addr);
    checks++; if (ok !== 1'b1 || addr !== 32'h300 || out_valid !== 1'b1 || out_data !== 32'h7F) begin failures++; $display("FAIL rstmid_next: got ok=%b addr=%h v=%b %h expected 1 300 1 7f", ok, addr, out_valid, out_data); end
    release_out();
  endtask

  task automatic test_rv64();
    logic [2:0]  t  [3] = '{LOAD_WU, LOAD_W, LOAD_D};
    logic [31:0] a  [3] = '{32'h4, 32'h4, 32'h8};
    logic [63:0] d  [3] = '{64'hF000_0001_1234_5678, 64'hF000_0001_1234_5678, 64'h8877_6655_4433_2211};
    logic [31:0] ma [3] = '{32'h0, 32'h0, 32'h8};
    logic [63:0] e  [3] = '{64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001, 64'h8877_6655_4433_2211};
    logic ok; logic [31:0] addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid64 = 1'b1; in_type64 = t[i]; in_addr64 = a[i];
      @(negedge clk); in_valid64 = 1'b0;
      ok = 1'b0; addr = '0;
      for (int k = 0; k < 20 && !ok; k++) begin
        if (mem_req_valid64 === 1'b1) begin ok = 1'b1; addr = mem_addr64; end
        else @(negedge clk);
      end
      mem_req_ready64 = 1'b1; @(negedge clk); mem_req_ready64 = 1'b0;
      mem_rsp_valid64 = 1'b1; mem_rdata64 = d[i]; @(negedge clk); mem_rsp_valid64 = 1'b0;
      checks++; if (ok !== 1'b1 || addr !== ma[i]) begin failures++; $display("FAIL rv64_req[%0d]: got ok=%b addr=%h expected 1 %h", i, ok, addr, ma[i]); end
      checks++; if (out_valid64 !== 1'b1 || out_data64 !== e[i] || {out_mis64, out_ill64} !== 2'b00) begin failures++; $display("FAIL rv64_data[%0d]: got v=%b %h exc=%b expected 1 %h 00", i, out_valid64, out_data64, {out_mis64, out_ill64}, e[i]); end
      out_ready64 = 1'b1; @(negedge clk); out_ready64 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_type = '0; in_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    in_valid64 = 1'b0; in_type64 = '0; in_addr64 = '0;
    mem_req_ready64 = 1'b0; mem_rsp_valid64 = 1'b0; mem_rdata64 = '0; out_ready64 = 1'b0;
    test_reset();
    test_inword();
    test_cross();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_rv64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
